// File: rtl/tim_irq_ctrl.sv
// Timer interrupt / DMA control block.
// Holds the interrupt/DMA enable register (DIER) and the status register (SR).
// SR holds the per-channel event flags and the overcapture flags.
// Produces one level interrupt and per-channel DMA requests with an ack handshake.
module tim_irq_ctrl #(
    parameter int N_CH   = 4,
    parameter bit DMA_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_dier,
    input  logic [2*N_CH-1:0]   i_dier,
    input  logic                ld_sr,
    input  logic [2*N_CH-1:0]   i_sr,
    input  logic [N_CH-1:0]     evt,
    input  logic [N_CH-1:0]     dma_ack,
    output logic [2*N_CH-1:0]   o_dier,
    output logic [2*N_CH-1:0]   o_sr,
    output logic                irq,
    output logic [N_CH-1:0]     dma_req
);

    logic [N_CH-1:0] ie_q, ie_d;
    logic [N_CH-1:0] de_q, de_d;
    logic [N_CH-1:0] flag_q, flag_d;
    logic [N_CH-1:0] ovf_q, ovf_d;
    logic [N_CH-1:0] req_q, req_d;
    logic [N_CH-1:0] sw_clr_flag;
    logic [N_CH-1:0] sw_clr_ovf;

    // Write-0-to-clear masks from an SR write
    assign sw_clr_flag = {N_CH{ld_sr}} & ~i_sr[N_CH-1:0];
    assign sw_clr_ovf  = {N_CH{ld_sr}} & ~i_sr[2*N_CH-1:N_CH];

    // DIER load; DMA enables are forced to zero in builds without DMA
    always_comb begin
        ie_d = ie_q;
        de_d = de_q;
        if (ld_dier) begin
            ie_d = i_dier[N_CH-1:0];
            de_d = DMA_EN ? i_dier[2*N_CH-1:N_CH] : '0;
        end
    end

    // Event flags and overcapture flags; a hardware set always beats a clear
    always_comb begin
        flag_d = flag_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < N_CH; i++) begin
            if (evt[i])
                flag_d[i] = 1'b1;
            else if (sw_clr_flag[i])
                flag_d[i] = 1'b0;
            else if (dma_ack[i] && req_q[i])
                flag_d[i] = 1'b0;

            if (evt[i] && flag_q[i])
                ovf_d[i] = 1'b1;
            else if (sw_clr_ovf[i])
                ovf_d[i] = 1'b0;
        end
        // The update channel has no overcapture bit
        ovf_d[0] = 1'b0;
    end

    // DMA request: raised by an enabled event, held only while its flag stays set
    // and DMA stays enabled, so an ack, a SW clear or a DE clear all withdraw it
    always_comb begin
        req_d = de_d & flag_d & ((evt & de_q) | req_q);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q   <= '0;
            de_q   <= '0;
            flag_q <= '0;
            ovf_q  <= '0;
            req_q  <= '0;
        end else begin
            ie_q   <= ie_d;
            de_q   <= de_d;
            flag_q <= flag_d;
            ovf_q  <= ovf_d;
            req_q  <= req_d;
        end
    end

    assign o_dier  = {de_q, ie_q};
    assign o_sr    = {ovf_q, flag_q};
    assign irq     = |(flag_q & ie_q);
    assign dma_req = req_q;

endmodule
